coherent_frame_averager: RTL

//  Downstream of the mean-removal stage. Averages 2**LOG2_K consecutive frames of M samples, sample-by-sample.

---
 rtl/coherent_frame_averager.sv | 116 +++++++++++
 1 files changed

// File: rtl/coherent_frame_averager.sv
// coherent_frame_averager: averages 2**LOG2_K consecutive frames of M
// samples, sample-by-sample, streaming the averaged frame out during the
// last frame of each block with a fixed 2-cycle latency.
// Ports: clock, reset (sync, active-high), restart (re-align counters),
//   data_in/data_in_valid (signed samples, no backpressure),
//   data_out/data_out_valid (averaged sample), frame_done (last sample of
//   averaged frame), sample_idx (index of next expected sample).
// Option: define AVG_ROUNDING_EN for round-half-up with saturation;
//   otherwise the average is a plain floor (arithmetic shift).
module coherent_frame_averager #(
  parameter int M      = 32,
  parameter int LOG2_K = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        restart,
  input  logic [31:0] data_in,
  input  logic        data_in_valid,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic        frame_done,
  output logic [15:0] sample_idx
);

  localparam int AW = 32 + LOG2_K;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [15:0]       LAST_IDX = 16'(M - 1);
  localparam logic [IW-1:0]     LAST_MEM = IW'(M - 1);
  localparam logic [LOG2_K-1:0] LAST_FRM = '1;

  logic signed [AW-1:0] acc_mem [M];

  logic [15:0]       idx;
  logic [LOG2_K-1:0] frame;

  logic                 s1_valid;
  logic [31:0]          s1_data;
  logic [IW-1:0]        s1_idx;
  logic [LOG2_K-1:0]    s1_frame;
  logic signed [AW-1:0] s1_acc;

  logic signed [AW-1:0] sext;
  logic signed [AW-1:0] sum;
  logic [31:0]          avg;
  logic                 s1_last;

  assign sample_idx = idx;

  // Sample/frame counters; restart wins over a same-cycle valid sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx   <= '0;
      frame <= '0;
    end else if (restart) begin
      idx   <= '0;
      frame <= '0;
    end else if (data_in_valid) begin
      if (idx == LAST_IDX) begin
        idx   <= '0;
        frame <= frame + LOG2_K'(1);
      end else begin
        idx <= idx + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= data_in_valid && !restart;
  end

  always_ff @(posedge clock) begin
    s1_data  <= data_in;
    s1_idx   <= idx[IW-1:0];
    s1_frame <= frame;
    s1_acc   <= acc_mem[idx[IW-1:0]];
  end

  assign sext    = {{LOG2_K{s1_data[31]}}, s1_data};
  assign sum     = s1_acc + sext;
  assign s1_last = (s1_frame == LAST_FRM);

`ifdef AVG_ROUNDING_EN
  localparam logic [AW:0] RND = (AW + 1)'(1) << (LOG2_K - 1);
  logic signed [AW:0] rsum;
  logic signed [AW:0] rsh;
  logic               ovf;
  assign rsum = {sum[AW-1], sum} + RND;
  assign rsh  = rsum >>> LOG2_K;
  // Only positive overflow is reachable (rounding up from +max).
  assign ovf  = !rsh[AW] && (rsh[AW-1:31] != '0);
  assign avg  = ovf ? 32'h7FFF_FFFF : rsh[31:0];
`else
  assign avg  = 32'(sum >>> LOG2_K);
`endif

  // Frame 0 overwrites, so no clear sweep between blocks is needed.
  always_ff @(posedge clock) begin
    if (!reset && s1_valid && !s1_last) begin
      acc_mem[s1_idx] <= (s1_frame == '0) ? sext : sum;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      data_out_valid <= s1_valid && s1_last;
      frame_done     <= s1_valid && s1_last && (s1_idx == LAST_MEM);
      if (s1_valid && s1_last) data_out <= avg;
    end
  end

endmodule
